// File: rtl/uart_msg_pkg.sv
// Shared FSM encoding, ASCII constants and message-length helper for the UART message framer.
package uart_msg_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam byte_t ASC_COLON = 8'h3A;
    localparam byte_t ASC_ZERO  = 8'h30;
    localparam byte_t ASC_QMARK = 8'h3F;
    localparam byte_t ASC_CR    = 8'h0D;
    localparam byte_t ASC_LF    = 8'h0A;

    function automatic int msg_len(input int prefix_len, input int field_num, input int eol_en);
        return prefix_len + 3 * field_num - 1 + 2 * eol_en;
    endfunction

    // Non-decimal nibbles are flagged rather than wrapped into a digit.
    function automatic byte_t bcd_ascii(input logic [3:0] nib);
        return (nib > 4'd9) ? ASC_QMARK : (ASC_ZERO + {4'd0, nib});
    endfunction

endpackage

// File: rtl/uart_msg_sender_if.sv
// Byte/valid link to the UART transmitter, qualified by the transmitter's busy flag.
interface uart_msg_sender_if;
    import uart_msg_pkg::*;

    byte_t tx_dout;
    logic  tx_dout_vld;
    logic  tx_busy;

    modport master (output tx_dout, output tx_dout_vld, input tx_busy);
    modport slave  (input tx_dout, input tx_dout_vld, output tx_busy);
endinterface

// File: rtl/period_tick.sv
// Free-running period timer: one-cycle tick every PERIOD_CYC enabled cycles.
// Latency: first tick PERIOD_CYC cycles after clr drops with ena high.
// Backpressure: none; clr dominates and holds the count at zero.
module period_tick #(
    parameter int PERIOD_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic ena,
    output logic tick
);
    localparam int CW = $clog2(PERIOD_CYC);
    localparam logic [CW-1:0] TC = CW'(PERIOD_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (ena) begin
            tick <= (cnt == TC);
            cnt  <= (cnt == TC) ? '0 : cnt + 1'b1;
        end else begin
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_msg_sender.sv
// Frames <prefix>DD:..:DD[CRLF] from a snapshot and streams it byte-wise to a UART.
// Latency: start request -> LOAD next cycle -> SEND, strobe registered out of SEND.
// Backpressure: waits for tx_busy low before each byte; ack wait bounded by ACK_TIMEOUT.
module uart_msg_sender
    import uart_msg_pkg::*;
#(
    parameter int PREFIX_LEN  = 8,
    parameter int FIELD_NUM   = 3,
    parameter int EOL_EN      = 1,
    parameter int PERIOD_CYC  = 50_000_000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    trig,
    input  logic [PREFIX_LEN*8-1:0] prefix,
    input  logic [FIELD_NUM*8-1:0]  bcd_data,
    uart_msg_sender_if.master       tx,
    output logic                    msg_busy,
    output logic                    msg_done,
    output logic [7:0]              drop_cnt
);
    localparam int MSG_LEN = msg_len(PREFIX_LEN, FIELD_NUM, EOL_EN);
    localparam int CNT_W   = $clog2(MSG_LEN);
    localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    logic [2:0]           state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [TO_W-1:0]      to_cnt;
    logic [MSG_LEN*8-1:0] fmt, msg_q;
    byte_t                dout_q;
    logic                 dout_vld_q;
    logic                 tick, run, start_req, last_byte, done_now, drop_req;

    assign run = en & ~mode;

    period_tick #(.PERIOD_CYC(PERIOD_CYC)) u_period_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~run),
        .ena   (run),
        .tick  (tick)
    );

    assign start_req = en & (mode ? trig : tick);
    assign last_byte = (cnt == LAST_IDX);
    assign done_now  = (state == ST_DRAIN) && !tx.tx_busy && last_byte;
    // The request landing on the final drain exit chains straight into the next message.
    assign drop_req  = start_req && (state != ST_IDLE) && !done_now;

    // Byte i of the message lives at fmt[i*8 +: 8].
    for (genvar i = 0; i < PREFIX_LEN; i++) begin : g_pfx
        assign fmt[i*8 +: 8] = prefix[(PREFIX_LEN-1-i)*8 +: 8];
    end
    for (genvar f = 0; f < FIELD_NUM; f++) begin : g_fld
        localparam int B = PREFIX_LEN + 3 * f;
        assign fmt[B*8 +: 8]     = bcd_ascii(bcd_data[(FIELD_NUM-1-f)*8+4 +: 4]);
        assign fmt[(B+1)*8 +: 8] = bcd_ascii(bcd_data[(FIELD_NUM-1-f)*8 +: 4]);
        if (f < FIELD_NUM - 1) begin : g_sep
            assign fmt[(B+2)*8 +: 8] = ASC_COLON;
        end
    end
    if (EOL_EN != 0) begin : g_eol
        assign fmt[(MSG_LEN-2)*8 +: 8] = ASC_CR;
        assign fmt[(MSG_LEN-1)*8 +: 8] = ASC_LF;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_req) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SEND;
            ST_SEND:  if (!tx.tx_busy) state_nxt = ST_ACK;
            ST_ACK:   if (tx.tx_busy || to_cnt == TO_LAST) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!tx.tx_busy)
                          state_nxt = last_byte ? (start_req ? ST_LOAD : ST_IDLE) : ST_SEND;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == ST_LOAD) msg_q <= fmt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            to_cnt     <= '0;
            dout_q     <= 8'h00;
            dout_vld_q <= 1'b0;
            msg_busy   <= 1'b0;
            msg_done   <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            state      <= state_nxt;
            msg_busy   <= (state_nxt != ST_IDLE);
            msg_done   <= done_now;
            dout_vld_q <= (state == ST_SEND) && !tx.tx_busy;
            if ((state == ST_SEND) && !tx.tx_busy) dout_q <= msg_q[{cnt, 3'b000} +: 8];
            to_cnt     <= (state == ST_ACK) ? to_cnt + 1'b1 : '0;
            if (state == ST_LOAD) begin
                cnt <= '0;
            end else if ((state == ST_DRAIN) && !tx.tx_busy && !last_byte) begin
                cnt <= cnt + 1'b1;
            end
            if (drop_req && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign tx.tx_dout     = dout_q;
    assign tx.tx_dout_vld = dout_vld_q;
endmodule
